// File: rtl/draw_cmd_pkg.sv
// Shared constants, word formats and FSM encoding for the DrawUnit command arbiter.
package draw_cmd_pkg;

   localparam int COLOR_LSB = 7;
   localparam int Y_LSB     = 0;
   localparam int X_LSB     = 0;

   localparam logic [15:0] SYNC_WORD = 16'hFFFF;

   localparam int XMAX_DEF = 160;
   localparam int YMAX_DEF = 120;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_W0,
      ST_W1,
      ST_SYNC
   } state_e;

   function automatic logic [15:0] pixel_word0(input logic [2:0] color, input logic [6:0] y);
      logic [15:0] w;
      w = '0;
      w[COLOR_LSB +: 3] = color;
      w[Y_LSB +: 7]     = y;
      return w;
   endfunction

   function automatic logic [15:0] pixel_word1(input logic [7:0] x);
      logic [15:0] w;
      w = '0;
      w[X_LSB +: 8] = x;
      return w;
   endfunction

endpackage

// File: rtl/draw_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts one past the last winner.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic          en_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o
);

   always_comb begin
      logic found;
      int   j;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(last_i) + k) % N;
         if (en_i && !found && req_i[j]) begin
            found      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/draw_cmd_arbiter.sv
// Serialises one command at a time from NREQ requesters into DrawUnit FIFO words.
//
//  state   | meaning
//  IDLE    | arbitrate, accept one command, latch its fields
//  W0      | write pixel word0 {color,y} when FIFO not full
//  W1      | write pixel word1 {x} when FIFO not full, command done
//  SYNC    | write 16'hFFFF when FIFO not full, command done
module draw_cmd_arbiter
   import draw_cmd_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int XMAX = XMAX_DEF,
   parameter int YMAX = YMAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ-1:0]   req_sync,
   input  logic [3*NREQ-1:0] req_color,
   input  logic [7*NREQ-1:0] req_y,
   input  logic [8*NREQ-1:0] req_x,
   input  logic              full,
   output logic              we,
   output logic [15:0]       data,
   output logic              err_drop,
   output logic [15:0]       cmd_count
);

   localparam int IW = $clog2(NREQ);

   state_e          state_q, state_d;
   logic [IW-1:0]   last_q, last_d;
   logic [IW-1:0]   gidx;
   logic [NREQ-1:0] grant;
   logic [2:0]      color_q, color_d;
   logic [6:0]      y_q, y_d;
   logic [7:0]      x_q, x_d;
   logic            err_q, err_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            idle_en, accept, sel_sync, oor;
   logic [2:0]      sel_color;
   logic [6:0]      sel_y;
   logic [7:0]      sel_x;

   // reset gates the grant so req_ready stays low while reset is asserted
   assign idle_en = (state_q == ST_IDLE) && reset;

   rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
      .req_i   (req_valid),
      .en_i    (idle_en),
      .last_i  (last_q),
      .grant_o (grant),
      .idx_o   (gidx)
   );

   assign req_ready = grant;
   assign accept    = |grant;
   assign sel_sync  = req_sync[gidx];
   assign sel_color = req_color[3*gidx +: 3];
   assign sel_y     = req_y[7*gidx +: 7];
   assign sel_x     = req_x[8*gidx +: 8];
   assign oor       = ({1'b0, sel_y} >= 8'(YMAX)) || ({1'b0, sel_x} >= 9'(XMAX));

   assign err_drop  = err_q;
   assign cmd_count = cnt_q;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      color_d = color_q;
      y_d     = y_q;
      x_d     = x_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      we      = 1'b0;
      data    = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               last_d  = gidx;
               color_d = sel_color;
               y_d     = sel_y;
               x_d     = sel_x;
               if (sel_sync)  state_d = ST_SYNC;
               else if (oor)  err_d   = 1'b1;
               else           state_d = ST_W0;
            end
         end
         ST_W0: begin
            data = pixel_word0(color_q, y_q);
            we   = !full;
            if (!full) state_d = ST_W1;
         end
         ST_W1: begin
            data = pixel_word1(x_q);
            we   = !full;
            if (!full) begin
               state_d = ST_IDLE;
               cnt_d   = cnt_q + 16'd1;
            end
         end
         ST_SYNC: begin
            data = SYNC_WORD;
            we   = !full;
            if (!full) begin
               state_d = ST_IDLE;
               cnt_d   = cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         last_q  <= IW'(NREQ - 1);
         color_q <= '0;
         y_q     <= '0;
         x_q     <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         color_q <= color_d;
         y_q     <= y_d;
         x_q     <= x_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_draw_cmd_arbiter.sv
// Bench for draw_cmd_arbiter: queue-based word-stream model plus directed literal checks.
module tb_draw_cmd_arbiter;

   localparam int NREQ = 2;
   localparam int XMAX = 160;
   localparam int YMAX = 120;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   req_sync;
   logic [3*NREQ-1:0] req_color;
   logic [7*NREQ-1:0] req_y;
   logic [8*NREQ-1:0] req_x;
   logic              full;
   logic              we;
   logic [15:0]       data;
   logic              err_drop;
   logic [15:0]       cmd_count;

   always #5 clk = ~clk;

   draw_cmd_arbiter #(.NREQ(NREQ), .XMAX(XMAX), .YMAX(YMAX)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_sync  (req_sync),
      .req_color (req_color),
      .req_y     (req_y),
      .req_x     (req_x),
      .full      (full),
      .we        (we),
      .data      (data),
      .err_drop  (err_drop),
      .cmd_count (cmd_count)
   );

   typedef struct {
      bit         sync;
      logic [2:0] color;
      logic [6:0] y;
      logic [7:0] x;
   } cmd_t;

   cmd_t        rq[NREQ][$];
   logic [15:0] wq[$];
   int          ptr;
   int          mcnt;
   bit          err_pend;
   int          checks;
   int          failures;
   int          grant_log[$];
   logic        last_we;
   logic [15:0] last_data;
   logic        last_err;
   logic [NREQ-1:0] last_ready;

   function automatic cmd_t mk(input bit s, input int c, input int yy, input int xx);
      cmd_t r;
      r.sync  = s;
      r.color = 3'(c);
      r.y     = 7'(yy);
      r.x     = 8'(xx);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NREQ; i++) begin
         if (rq[i].size() > 0) begin
            req_valid[i]         = 1'b1;
            req_sync[i]          = rq[i][0].sync;
            req_color[3*i +: 3]  = rq[i][0].color;
            req_y[7*i +: 7]      = rq[i][0].y;
            req_x[8*i +: 8]      = rq[i][0].x;
         end else begin
            req_valid[i] = 1'b0;
         end
      end
   endtask

   // one clock: called at a negedge, returns at the next negedge
   task automatic step();
      logic [NREQ-1:0] e_ready;
      logic            e_we;
      logic [15:0]     e_data;
      int              g;
      cmd_t            c;
      drive_inputs();
      #1;
      e_ready = '0;
      e_we    = 1'b0;
      e_data  = 16'h0000;
      g       = -1;
      if (reset) begin
         if (wq.size() > 0) begin
            e_we   = !full;
            e_data = wq[0];
         end else begin
            for (int k = 1; k <= NREQ; k++) begin
               int j;
               j = (ptr + k) % NREQ;
               if (g < 0 && req_valid[j]) g = j;
            end
            if (g >= 0) e_ready[g] = 1'b1;
         end
      end
      check("ready", 32'(req_ready), 32'(e_ready));
      check("we", 32'(we), 32'(e_we));
      if (e_we || wq.size() == 0 || !reset) check("data", 32'(data), 32'(e_data));
      check("err_drop", 32'(err_drop), reset ? 32'(err_pend) : 32'd0);
      check("cmd_count", 32'(cmd_count), reset ? 32'(mcnt) : 32'd0);
      last_we    = we;
      last_data  = data;
      last_err   = err_drop;
      last_ready = req_ready;
      if (!reset) begin
         wq.delete();
         ptr      = NREQ - 1;
         mcnt     = 0;
         err_pend = 1'b0;
      end else begin
         err_pend = 1'b0;
         if (wq.size() > 0) begin
            if (!full) begin
               void'(wq.pop_front());
               if (wq.size() == 0) mcnt = (mcnt + 1) % 65536;
            end
         end else if (g >= 0) begin
            c   = rq[g][0];
            ptr = g;
            if (c.sync) wq.push_back(16'hFFFF);
            else if (int'(c.y) >= YMAX || int'(c.x) >= XMAX) err_pend = 1'b1;
            else begin
               wq.push_back({6'b0, c.color, c.y});
               wq.push_back({8'b0, c.x});
            end
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            void'(rq[i].pop_front());
            grant_log.push_back(i);
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      int rdy1, nwr;
      checks    = 0;
      failures  = 0;
      ptr       = NREQ - 1;
      mcnt      = 0;
      err_pend  = 1'b0;
      reset     = 1'b0;
      full      = 1'b0;
      req_valid = '0;
      req_sync  = '0;
      req_color = '0;
      req_y     = '0;
      req_x     = '0;
      @(negedge clk);

      // reset state, with a pending request that must not be granted
      rq[0].push_back(mk(0, 1, 1, 1));
      step();
      check("rst_ready", 32'(last_ready), 32'd0);
      step();
      rq[0].delete();
      reset = 1'b1;

      // single pixel
      rq[0].push_back(mk(0, 3'b101, 5, 159));
      step();
      check("t1_grant", 32'(last_ready), 32'd1);
      step();
      check("t1_w0_we", 32'(last_we), 32'd1);
      check("t1_w0", 32'(last_data), 32'h0285);
      step();
      check("t1_w1_we", 32'(last_we), 32'd1);
      check("t1_w1", 32'(last_data), 32'h009F);
      step();
      check("t1_cnt", 32'(cmd_count), 32'd1);

      // backpressure
      rq[0].push_back(mk(0, 3'b101, 5, 159));
      step();
      full = 1'b1;
      repeat (4) begin
         step();
         check("t2_stall_we", 32'(last_we), 32'd0);
      end
      full = 1'b0;
      step();
      check("t2_w0", 32'(last_data), 32'h0285);
      check("t2_w0_we", 32'(last_we), 32'd1);
      step();
      check("t2_w1", 32'(last_data), 32'h009F);
      step();
      check("t2_nodup", 32'(last_we), 32'd0);
      check("t2_cnt", 32'(cmd_count), 32'd2);

      // contention
      do_reset();
      for (int i = 0; i < 3; i++) begin
         rq[0].push_back(mk(0, i, 10 + i, 20 + i));
         rq[1].push_back(mk(0, 7 - i, 100 + i, 150 + i));
      end
      grant_log.delete();
      repeat (20) step();
      check("t3_ngrants", 32'(grant_log.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         if (i < grant_log.size()) check("t3_grant", 32'(grant_log[i]), 32'(i % 2));

      // sync from requester 1
      rq[1].push_back(mk(1, 0, 0, 0));
      rdy1 = 0;
      nwr  = 0;
      repeat (4) begin
         step();
         if (last_ready[1]) rdy1++;
         if (last_we && last_data == 16'hFFFF) nwr++;
      end
      check("t4_ready_cycles", 32'(rdy1), 32'd1);
      check("t4_sync_writes", 32'(nwr), 32'd1);

      // out of range y then x
      nwr = 0;
      rq[0].push_back(mk(0, 2, 120, 3));
      step();
      if (last_we) nwr++;
      step();
      if (last_we) nwr++;
      check("t5_err_y", 32'(last_err), 32'd1);
      rq[1].push_back(mk(0, 2, 0, 160));
      step();
      if (last_we) nwr++;
      check("t5_err_once", 32'(last_err), 32'd0);
      step();
      if (last_we) nwr++;
      check("t5_err_x", 32'(last_err), 32'd1);
      step();
      if (last_we) nwr++;
      check("t5_nowrite", 32'(nwr), 32'd0);
      check("t5_cnt", 32'(cmd_count), 32'd7);

      // reset while holding word1
      rq[0].push_back(mk(0, 3'b010, 10, 20));
      step();
      step();
      check("t6_w0", 32'(last_data), 32'h010A);
      full = 1'b1;
      step();
      check("t6_hold_we", 32'(last_we), 32'd0);
      reset = 1'b0;
      full  = 1'b1;
      step();
      check("t6_rst_we", 32'(last_we), 32'd0);
      step();
      reset = 1'b1;
      full  = 1'b0;
      rq[1].push_back(mk(0, 3'b111, 0, 0));
      step();
      step();
      check("t6_new_w0_we", 32'(last_we), 32'd1);
      check("t6_new_w0", 32'(last_data), 32'h0380);
      step();
      check("t6_new_w1", 32'(last_data), 32'h0000);
      step();
      check("t6_cnt", 32'(cmd_count), 32'd1);

      // randomized traffic
      repeat (3000) begin
         full  = ($urandom % 4 == 0);
         reset = ($urandom % 700 != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() == 0 && $urandom % 3 == 0) begin
               int yy, xx;
               yy = (int'($urandom % 16) == 0) ? int'($urandom_range(127, 120)) : int'($urandom_range(119, 0));
               xx = (int'($urandom % 16) == 0) ? int'($urandom_range(255, 160)) : int'($urandom_range(159, 0));
               rq[i].push_back(mk(($urandom % 8) == 0, int'($urandom % 8), yy, xx));
            end
         end
         step();
      end
      reset = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/draw_cmd_arbiter.md
# draw_cmd_arbiter

Shares the DrawUnit command FIFO write port between NREQ drawing requesters. Each requester hands over one complete command (pixel plot or frame sync). The block serialises it into the 16-bit command words DrawUnit expects and drives `we`/`dataIn` while honouring `full`. A two-word pixel command is never interleaved with another requester's words. Sits between the CPU/painter engines and DrawUnit, replacing ad-hoc write sequencing at top level.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `XMAX`, 160: pixel x must be < XMAX.
- `YMAX`, 120: pixel y must be < YMAX.

- `clk`  in  1  system clock (same clock as DrawUnit `clk`).
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i holds a command.
- `req_ready`  out  NREQ  one-hot; command i accepted this cycle.
- `req_sync`  in  NREQ  1 = frame-sync command, 0 = pixel command.
- `req_color`  in  3*NREQ  {R,G,B} for requester i, slice [3i+2:3i].
- `req_y`  in  7*NREQ  row for requester i.
- `req_x`  in  8*NREQ  column for requester i.
- `full`  in  1  DrawUnit FIFO full.
- `we`  out  1  FIFO write strobe.
- `data`  out  16  FIFO write word.
- `err_drop`  out  1  one-cycle pulse: out-of-range pixel command discarded.
- `cmd_count`  out  16  commands issued since reset, wrapping.

## Operation
- Word formats:
  - pixel word0 = {6'b0, color[2:0], y[6:0]}
  - pixel word1 = {8'b0, x[7:0]}
  - sync = 16'hFFFF, single word.
- FSM states:
  - IDLE: round-robin grant among `req_valid`. Start search at (last_grant+1) mod NREQ. `req_ready[g]`=1 combinationally for the granted requester only; accept = valid&&ready. On accept, latch color/y/x/sync and update last_grant.
    - sync: -> SYNC.
    - pixel in range: -> W0.
    - pixel with y>=YMAX or x>=XMAX: pulse `err_drop` next cycle, stay IDLE.
  - W0: `data`=word0. `we` = !full. If !full -> W1, else hold.
  - W1: `data`=word1. `we` = !full. If !full -> IDLE and `cmd_count`+1, else hold.
  - SYNC: `data`=16'hFFFF. `we` = !full. If !full -> IDLE and `cmd_count`+1, else hold.
- `we` is combinational from state and `full`. A word is written exactly in a cycle where `we`=1 at the rising edge, so no overflow occurs even if `full` rises mid-command.
- `req_ready` is 0 in every state except IDLE. Requesters must hold their fields stable while valid.
- `data` is don't-care when `we`=0, but is driven 16'h0000 in IDLE.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, last_grant=NREQ-1 (requester 0 wins first).
  - `we`=0, `data`=0, `req_ready`=0, `err_drop`=0, `cmd_count`=0.
- Reset mid-command: the latched command is discarded. `we` falls immediately with reset; no partial word pair is resumed.
- Pixel with `full`=0 throughout: accept at cycle n, word0 at n+1, word1 at n+2, next accept at n+3. Throughput is one pixel per 3 cycles.
- Sync with `full`=0: accept n, write n+1, next accept n+2.
- `full` stalls extend W0/W1/SYNC one cycle each; there is no timeout.
- Simultaneous valids: exactly one grant per IDLE cycle. Equal requesters alternate strictly.

## Structure
- Package `draw_cmd_pkg`:
  - word field positions (COLOR_LSB=7, Y_LSB=0, X_LSB=0)
  - `SYNC_WORD`=16'hFFFF
  - default XMAX/YMAX
  - FSM state encoding {IDLE, W0, W1, SYNC}
- Sub-module `rr_arbiter`:
  - parameter N
  - inputs: req vector, enable, last_grant
  - outputs: one-hot grant and encoded index
  - purely combinational; the pointer register lives in `draw_cmd_arbiter`.

## Test plan
- Single pixel: req0 color=3'b101, y=5, x=159, `full`=0 -> `we` high 2 cycles, data 16'h0285 then 16'h009F; `cmd_count`=1.
- Backpressure: `full`=1 from cycle after accept for 4 cycles -> `we`=0 during stall, 16'h0285 written on first non-full cycle, no duplicate words.
- Contention: req0 and req1 both valid with 3 pixels each -> grants 0,1,0,1,0,1. Word pairs are never interleaved.
- Sync: req1 sync while req0 idle -> one write of 16'hFFFF, `req_ready[1]` for exactly one cycle.
- Out-of-range: y=120 or x=160 -> accepted, `err_drop` pulses once, no write, `cmd_count` unchanged.
- Reset in W1 with `full`=1 -> `we`=0 immediately, state IDLE after release, a new command issues normally starting with word0.
